bcd_counter_ctrl: RTL and testbench
===================================

Name: bcd_counter_ctrl

Overview:
Run/stop sequencer for a multi-digit up/down counter, selectable hex or BCD per digit.
- Generates the count-enable tick from `clk` through an internal prescaler.
- Chains carry and borrow across digits.
- Handles start, stop and preset-load commands.
- Detects terminal count, then either wraps or stops.
- Time-multiplexes the digits onto a single 7-segment decoder input.
- Sits between the board buttons/switches and the seven-segment display path.

Parameters:
- DIGITS, 4, number of 4-bit digits in the count.
- DIV, 100000, `clk` cycles per count tick; must be ≥2.
- SCAN_DIV, 1000, `clk` cycles per display-digit advance; must be ≥2.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle command: begin or resume counting.
- stop  in  1  single-cycle command: pause counting.
- load  in  1  single-cycle command: load `preset` into `count`.
- Mode  in  1  direction: 0 = up, 1 = down.
- m  in  1  digit radix: 0 = hex (0–15), 1 = BCD (0–9).
- wrap  in  1  at terminal count: 1 = wrap and continue, 0 = stop in DONE.
- preset  in  4*DIGITS  load value; digit 0 in bits [3:0].
- count  out  4*DIGITS  current count, registered.
- running  out  1  high while in RUN.
- tc  out  1  one-cycle pulse when a tick occurs at terminal count.
- state  out  2  FSM state: IDLE=00, RUN=01, PAUSE=10, DONE=11.
- an  out  DIGITS  active-low one-hot digit enable.
- digit  out  4  nibble of `count` for the currently scanned digit.

Behaviour:
Reset (synchronous, on `clk` rising edge with `reset`=1):
- `count`=0, `state`=IDLE, `running`=0, `tc`=0.
- Prescaler=0, scan index=0, `an`=~1 (digit 0 enabled), `digit`=0.

Command priority in every cycle: `load` > `stop` > `start`.
- `load` in any state: `count`←`preset`, prescaler←0, `state`←IDLE.
  - With `m`=1, any preset digit >9 loads as 9.

State transitions:
- IDLE: `start` → RUN.
- RUN: `stop` → PAUSE.
- PAUSE: `start` → RUN.
- DONE: `start` → RUN, which reloads `count` to 0 if `Mode`=0, or to all-max if `Mode`=1, before counting resumes.
- `start` while in RUN and `stop` outside RUN have no effect.

Prescaler:
- Counts 0..DIV-1 only in RUN; holds its value in PAUSE.
- Cleared on entering RUN from IDLE or DONE.
- tick = (prescaler == DIV-1) and in RUN. First tick occurs DIV cycles after `start` is sampled.

Digit stepping on a tick (max = 9 if `m`=1, else 15):
- Up: digit 0 increments. Digit i steps only when all lower digits equal max; a digit at max goes to 0.
- Down: digit 0 decrements. Digit i steps only when all lower digits equal 0; a digit at 0 goes to max.
- With `m`=1, a digit >9 is treated as 9 for stepping: up gives 0 with carry; down gives 8.

Terminal count is all digits at max (up) or all digits 0 (down).
- A tick at terminal count pulses `tc`=1 for exactly one cycle.
- If `wrap`=1, the count rolls over (all-max→0 up, 0→all-max down).
- If `wrap`=0, `count` holds and `state`←DONE in the same edge.

Live inputs:
- `Mode`, `m` and `wrap` are sampled on each tick; changes take effect at the next tick.
- `stop` in the same cycle as a tick: the tick still applies, then `state`←PAUSE.

Display scan:
- Free-running scan counter, independent of `state`.
- Every SCAN_DIV cycles the scan index advances mod DIGITS.
- `an`=~(1<<index); `digit`=`count` nibble[index]. Both registered, one cycle of latency from `count`.

Test Plan (DIV=4, SCAN_DIV=3, DIGITS=2):
- Reset then `start`, `Mode`=0, `m`=1: `count` goes 00→01 four cycles after `start`; after 10 ticks, 09→10 (BCD carry); `running`=1, `state`=01.
- `load` `preset`=0x98, `start`, `m`=1, `wrap`=0, up: tick 98→99, next tick `tc` pulses, `count` holds 99, `state`=11, `running`=0.
- `m`=0, `Mode`=1, `wrap`=1, `preset`=0x00, run: first tick gives `count`=FF with a one-cycle `tc`; next tick FE.
- RUN, `stop` at prescaler=2 → PAUSE with `count` frozen; `start` 5 cycles later → next tick 2 cycles after resume (prescaler retained).
- `load`+`stop`+`start` in the same cycle while in RUN → `count`=`preset`, `state`=00; `reset` asserted mid-count → `count`=00, `an`=2'b10, `state`=00 next edge.
- `m`=1 with `preset`=0x3C: loads as 0x39; scan shows `an` sequence 10,01,10 every 3 cycles with `digit`=9,3,9.

Source files
------------

// File: rtl/bcd_counter_ctrl_if.sv
// Command, control and display signals of the BCD/hex counter sequencer.
// The controller uses the slave side; the board/bench drives the master side.
interface bcd_counter_ctrl_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  start;
  logic                  stop;
  logic                  load;
  logic                  Mode;
  logic                  m;
  logic                  wrap;
  logic [4*DIGITS-1:0]   preset;
  logic [4*DIGITS-1:0]   count;
  logic                  running;
  logic                  tc;
  logic [1:0]            state;
  logic [DIGITS-1:0]     an;
  logic [3:0]            digit;

  modport master (
    output start, stop, load, Mode, m, wrap, preset,
    input  count, running, tc, state, an, digit
  );

  modport slave (
    input  start, stop, load, Mode, m, wrap, preset,
    output count, running, tc, state, an, digit
  );
endinterface

// File: rtl/bcd_counter_ctrl.sv
// Run/stop sequencer for a multi-digit up/down hex/BCD counter with a
// prescaled count tick, terminal-count handling and a multiplexed digit scan.
module bcd_counter_ctrl #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned DIV      = 100000,
  parameter int unsigned SCAN_DIV = 1000
) (
  input logic               clk,
  input logic               reset,
  bcd_counter_ctrl_if.slave bus
);
  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned PW = $clog2(DIV);
  localparam int unsigned SW = $clog2(SCAN_DIV);
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] PAUSE = 2'b10;
  localparam logic [1:0] DONE  = 2'b11;

  logic [1:0]        state_q, state_d;
  logic [W-1:0]      count_q, count_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic              tc_q, tc_d;
  logic [SW-1:0]     scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]     scan_idx_q, scan_idx_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [3:0]        digit_q, digit_d;

  logic              tick;
  logic              start_cmd;
  logic              terminal;
  logic [W-1:0]      stepped;
  logic [W-1:0]      load_val;
  logic [W-1:0]      all_max;

  function automatic logic [3:0] eff_digit(input logic [3:0] d, input logic bcd);
    return (bcd && (d > 4'd9)) ? 4'd9 : d;
  endfunction

  // Ripple the enable from digit 0 upward; the final carry is terminal count.
  function automatic logic [W-1:0] step_count(input  logic [W-1:0] c,
                                              input  logic         down,
                                              input  logic         bcd,
                                              output logic         term);
    logic [3:0] maxv;
    logic [3:0] e;
    logic       carry;
    maxv       = bcd ? 4'd9 : 4'd15;
    carry      = 1'b1;
    step_count = c;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      e = eff_digit(c[4*i +: 4], bcd);
      if (carry) begin
        if (down) step_count[4*i +: 4] = (e == 4'd0) ? maxv : e - 4'd1;
        else      step_count[4*i +: 4] = (e == maxv) ? 4'd0 : e + 4'd1;
      end
      carry = carry && (down ? (e == 4'd0) : (e == maxv));
    end
    term = carry;
  endfunction

  function automatic logic [W-1:0] sat_value(input logic [W-1:0] v, input logic bcd);
    sat_value = v;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      sat_value[4*i +: 4] = eff_digit(v[4*i +: 4], bcd);
    end
  endfunction

  function automatic logic [W-1:0] fill_max(input logic bcd);
    fill_max = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      fill_max[4*i +: 4] = bcd ? 4'd9 : 4'd15;
    end
  endfunction

  assign tick      = (state_q == RUN) && (presc_q == PW'(DIV - 1));
  // stop outranks start in every state, so a simultaneous pair never resumes
  assign start_cmd = bus.start && !bus.stop;

  always_comb begin
    stepped  = step_count(count_q, bus.Mode, bus.m, terminal);
    load_val = sat_value(bus.preset, bus.m);
    all_max  = fill_max(bus.m);
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;
    tc_d    = 1'b0;
    if (bus.load) begin
      count_d = load_val;
      presc_d = '0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_cmd) begin
            state_d = RUN;
            presc_d = '0;
          end
        end
        RUN: begin
          presc_d = tick ? '0 : presc_q + 1'b1;
          if (tick) begin
            tc_d = terminal;
            if (terminal && !bus.wrap) state_d = DONE;
            else                       count_d = stepped;
          end
          // a tick in the stop cycle is still applied before pausing
          if (bus.stop) state_d = PAUSE;
        end
        PAUSE: begin
          if (start_cmd) state_d = RUN;
        end
        DONE: begin
          if (start_cmd) begin
            state_d = RUN;
            presc_d = '0;
            count_d = bus.Mode ? all_max : '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      scan_idx_d = (scan_idx_q == IW'(DIGITS - 1)) ? '0 : scan_idx_q + 1'b1;
    end
    an_d             = '1;
    an_d[scan_idx_q] = 1'b0;
    digit_d          = count_q[4*scan_idx_q +: 4];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      presc_q    <= '0;
      tc_q       <= 1'b0;
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
      an_q       <= {{(DIGITS-1){1'b1}}, 1'b0};
      digit_q    <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      presc_q    <= presc_d;
      tc_q       <= tc_d;
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      an_q       <= an_d;
      digit_q    <= digit_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.state   = state_q;
  assign bus.running = (state_q == RUN);
  assign bus.tc      = tc_q;
  assign bus.an      = an_q;
  assign bus.digit   = digit_q;
endmodule

// File: tb/tb_bcd_counter_ctrl.sv
// Directed and randomized bench for bcd_counter_ctrl; a value-level model
// (integer count in radix 10 or 16) predicts every output each cycle.
module tb_bcd_counter_ctrl;
  localparam int D  = 2;
  localparam int DV = 4;
  localparam int SD = 3;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  bcd_counter_ctrl_if #(.DIGITS(D)) bus ();

  bcd_counter_ctrl #(.DIGITS(D), .DIV(DV), .SCAN_DIV(SD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [7:0] e_count;
  int         e_state, e_presc, e_sc, e_idx;
  logic       e_tc;
  logic [1:0] e_an;
  logic [3:0] e_digit;

  function automatic int decode(input logic [7:0] c, input logic bcd);
    int r, v, mult, n;
    r = bcd ? 10 : 16;
    v = 0;
    mult = 1;
    for (int i = 0; i < D; i++) begin
      n = int'(c[4*i +: 4]);
      if (bcd && n > 9) n = 9;
      v += n * mult;
      mult *= r;
    end
    return v;
  endfunction

  function automatic logic [7:0] encode(input int v, input int r);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < D; i++) begin
      c[4*i +: 4] = 4'(v % r);
      v = v / r;
    end
    return c;
  endfunction

  task automatic model_edge();
    int r, n, v;
    bit tk, term;
    if (reset) begin
      e_count = '0; e_state = 0; e_presc = 0; e_sc = 0; e_idx = 0;
      e_tc = 1'b0; e_an = 2'b10; e_digit = '0;
      return;
    end
    e_an = 2'b11;
    e_an[e_idx] = 1'b0;
    e_digit = e_count[4*e_idx +: 4];
    if (e_sc == SD - 1) begin e_sc = 0; e_idx = (e_idx + 1) % D; end
    else e_sc++;
    e_tc = 1'b0;
    if (bus.load) begin
      e_count = encode(decode(bus.preset, bus.m), bus.m ? 10 : 16);
      e_presc = 0;
      e_state = 0;
      return;
    end
    r = bus.m ? 10 : 16;
    n = r ** D;
    case (e_state)
      0: if (bus.start && !bus.stop) begin e_state = 1; e_presc = 0; end
      1: begin
        tk = (e_presc == DV - 1);
        e_presc = (e_presc + 1) % DV;
        if (tk) begin
          v = decode(e_count, bus.m);
          term = bus.Mode ? (v == 0) : (v == n - 1);
          e_tc = term;
          if (term && !bus.wrap) e_state = 3;
          else e_count = encode(bus.Mode ? (v + n - 1) % n : (v + 1) % n, r);
        end
        if (bus.stop) e_state = 2;
      end
      2: if (bus.start && !bus.stop) e_state = 1;
      default: if (bus.start && !bus.stop) begin
        e_state = 1;
        e_presc = 0;
        e_count = encode(bus.Mode ? n - 1 : 0, r);
      end
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      #1;
      chk("m_count",   32'(bus.count),   32'(e_count));
      chk("m_state",   32'(bus.state),   32'(e_state));
      chk("m_running", 32'(bus.running), 32'(e_state == 1));
      chk("m_tc",      32'(bus.tc),      32'(e_tc));
      chk("m_an",      32'(bus.an),      32'(e_an));
      chk("m_digit",   32'(bus.digit),   32'(e_digit));
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.load = 1'b0;
    bus.Mode = 1'b0; bus.m = 1'b0; bus.wrap = 1'b0; bus.preset = '0;
    cyc(1);
    chk("rst_count", 32'(bus.count), 32'h0);
    chk("rst_state", 32'(bus.state), 32'h0);
    chk("rst_an",    32'(bus.an),    32'h2);
    chk("rst_digit", 32'(bus.digit), 32'h0);
    reset = 1'b0;

    // BCD up count and carry into digit 1
    bus.Mode = 1'b0; bus.m = 1'b1; bus.wrap = 1'b1; bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    cyc(3);
    chk("first_tick_pre", 32'(bus.count), 32'h00);
    cyc(1);
    chk("first_tick", 32'(bus.count), 32'h01);
    cyc(32);
    chk("bcd_09", 32'(bus.count), 32'h09);
    cyc(4);
    chk("bcd_carry", 32'(bus.count), 32'h10);
    chk("run_running", 32'(bus.running), 32'h1);
    chk("run_state", 32'(bus.state), 32'h1);

    // terminal count without wrap
    bus.preset = 8'h98; bus.wrap = 1'b0; bus.load = 1'b1;
    cyc(1);
    bus.load = 1'b0;
    chk("load_98", 32'(bus.count), 32'h98);
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    cyc(4);
    chk("tick_99", 32'(bus.count), 32'h99);
    cyc(4);
    chk("done_tc", 32'(bus.tc), 32'h1);
    chk("done_hold", 32'(bus.count), 32'h99);
    chk("done_state", 32'(bus.state), 32'h3);
    chk("done_running", 32'(bus.running), 32'h0);
    cyc(1);
    chk("done_tc_clear", 32'(bus.tc), 32'h0);

    // hex down with wrap from zero
    bus.m = 1'b0; bus.Mode = 1'b1; bus.wrap = 1'b1; bus.preset = 8'h00; bus.load = 1'b1;
    cyc(1);
    bus.load = 1'b0; bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    cyc(4);
    chk("down_wrap_ff", 32'(bus.count), 32'hFF);
    chk("down_wrap_tc", 32'(bus.tc), 32'h1);
    cyc(1);
    chk("down_tc_once", 32'(bus.tc), 32'h0);
    cyc(3);
    chk("down_fe", 32'(bus.count), 32'hFE);

    // pause with prescaler retained
    cyc(1);
    bus.stop = 1'b1;
    cyc(1);
    bus.stop = 1'b0;
    chk("pause_state", 32'(bus.state), 32'h2);
    cyc(4);
    chk("pause_frozen", 32'(bus.count), 32'hFE);
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    chk("resume_state", 32'(bus.state), 32'h1);
    cyc(1);
    chk("resume_wait", 32'(bus.count), 32'hFE);
    cyc(1);
    chk("resume_tick", 32'(bus.count), 32'hFD);

    // load beats stop and start; reset mid-count
    bus.preset = 8'h42; bus.load = 1'b1; bus.stop = 1'b1; bus.start = 1'b1;
    cyc(1);
    bus.load = 1'b0; bus.stop = 1'b0; bus.start = 1'b0;
    chk("prio_count", 32'(bus.count), 32'h42);
    chk("prio_state", 32'(bus.state), 32'h0);
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    cyc(5);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("mid_rst_count", 32'(bus.count), 32'h0);
    chk("mid_rst_an", 32'(bus.an), 32'h2);
    chk("mid_rst_state", 32'(bus.state), 32'h0);

    // BCD saturation on load and digit scan
    bus.m = 1'b1; bus.preset = 8'h3C; bus.load = 1'b1;
    cyc(1);
    bus.load = 1'b0;
    chk("sat_load", 32'(bus.count), 32'h39);
    cyc(1);
    chk("scan0_an", 32'(bus.an), 32'h2);
    chk("scan0_digit", 32'(bus.digit), 32'h9);
    cyc(2);
    chk("scan1_an", 32'(bus.an), 32'h1);
    chk("scan1_digit", 32'(bus.digit), 32'h3);
    cyc(3);
    chk("scan2_an", 32'(bus.an), 32'h2);
    chk("scan2_digit", 32'(bus.digit), 32'h9);

    // randomized segments, radix fixed per segment
    for (int s = 0; s < 12; s++) begin
      bus.m = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       bus.preset = 8'h00;
        1:       bus.preset = 8'hFF;
        2:       bus.preset = 8'h99;
        default: bus.preset = 8'($urandom);
      endcase
      bus.load = 1'b1; bus.start = 1'b0; bus.stop = 1'b0;
      cyc(1);
      bus.load = 1'b0; bus.start = 1'b1;
      cyc(1);
      for (int c = 0; c < 80; c++) begin
        bus.Mode   = 1'($urandom_range(0, 1));
        bus.wrap   = ($urandom_range(0, 3) != 0);
        bus.start  = ($urandom_range(0, 9) == 0);
        bus.stop   = ($urandom_range(0, 14) == 0);
        bus.load   = ($urandom_range(0, 39) == 0);
        bus.preset = 8'($urandom);
        cyc(1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
